gpu_pixel_line_writer: RTL and testbench

Write-back stage directly downstream of the texel/pipeline control stage. It consumes the stage-2 pixel stream (valid, screen X/Y, final 16-bit colour, transparency), merges pixels that fall into the same 8-pixel VRAM line (16 bytes) into a staging buffer, and hands completed lines to the VRAM write arbiter through a double-buffered request/ack interface. It back-pressures the pixel pipeline via o_pause only when both buffers are occupied and a line change or flush needs a slot.

---
 rtl/gpu_pixel_line_writer_if.sv | 31 +++
 rtl/gpu_pixel_line_writer.sv | 76 +++++++
 tb/tb_gpu_pixel_line_writer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pixel_line_writer_if.sv
// Pixel-in / VRAM-line-out bus for the pixel line writer.
// The slave modport is the writer itself. The master modport is the side that
// drives pixels and acks lines (pipeline plus arbiter, or a bench).
interface gpu_pixel_line_writer_if;
    logic         i_validPixel;
    logic [9:0]   i_scrX;
    logic [8:0]   i_scrY;
    logic [15:0]  i_pixel;
    logic         i_transparent;
    logic         i_forceMask;
    logic         i_flush;
    logic         o_pause;
    logic         o_memWriteReq;
    logic [15:0]  o_memAdr;
    logic [127:0] o_memData;
    logic [7:0]   o_memMask;
    logic         i_memWriteAck;
    logic         o_idle;

    modport slave (
        input  i_validPixel, i_scrX, i_scrY, i_pixel, i_transparent, i_forceMask,
               i_flush, i_memWriteAck,
        output o_pause, o_memWriteReq, o_memAdr, o_memData, o_memMask, o_idle
    );

    modport master (
        output i_validPixel, i_scrX, i_scrY, i_pixel, i_transparent, i_forceMask,
               i_flush, i_memWriteAck,
        input  o_pause, o_memWriteReq, o_memAdr, o_memData, o_memMask, o_idle
    );
endinterface

// File: rtl/gpu_pixel_line_writer.sv
// Pixel write-back stage: merges pixels of one 8-pixel VRAM line in a staging
// buffer and hands finished lines to the VRAM arbiter through one output buffer.
module gpu_pixel_line_writer (
    input  logic                     clk,
    input  logic                     i_nrst,
    gpu_pixel_line_writer_if.slave   bus
);
    // Staging buffer (empty when mask is zero)
    logic [15:0]      sAdr;
    logic [7:0][15:0] sData;
    logic [7:0]       sMask;

    // Output buffer (pending while memWriteReq is set)
    logic             memWriteReq;
    logic [15:0]      memAdr;
    logic [7:0][15:0] memData;
    logic [7:0]       memMask;

    logic [15:0] tag;
    logic [2:0]  slot;
    logic [15:0] wrPix;
    logic        sEmpty, pixOpaque, lineChange, flushReq, pause, evict, acceptPix;

    // Decode the incoming pixel and work out eviction / back-pressure.
    // Pause looks only at the registered pending bit, so an acked O buffer
    // cannot be refilled in the same cycle.
    always_comb begin
        tag        = {bus.i_scrY, bus.i_scrX[9:3]};
        slot       = bus.i_scrX[2:0];
        wrPix      = {bus.i_pixel[15] | bus.i_forceMask, bus.i_pixel[14:0]};
        sEmpty     = (sMask == 8'h00);
        pixOpaque  = bus.i_validPixel & ~bus.i_transparent;
        lineChange = pixOpaque & ~sEmpty & (tag != sAdr);
        flushReq   = bus.i_flush & ~bus.i_validPixel & ~sEmpty;
        pause      = memWriteReq & (lineChange | flushReq);
        evict      = ~memWriteReq & (lineChange | flushReq);
        acceptPix  = pixOpaque & ~pause;
    end

    // Staging merge, eviction into the output buffer and ack handling.
    always_ff @(posedge clk) begin
        if (!i_nrst) begin
            sAdr        <= '0;
            sData       <= '0;
            sMask       <= '0;
            memWriteReq <= 1'b0;
            memAdr      <= '0;
            memData     <= '0;
            memMask     <= '0;
        end else begin
            if (memWriteReq && bus.i_memWriteAck)
                memWriteReq <= 1'b0;
            if (evict) begin
                memWriteReq <= 1'b1;
                memAdr      <= sAdr;
                memData     <= sData;
                memMask     <= sMask;
            end
            if (acceptPix) begin
                // A line change restarts the mask with just this pixel.
                sAdr        <= tag;
                sMask       <= (lineChange ? 8'h00 : sMask) | (8'h01 << slot);
                sData[slot] <= wrPix;
            end else if (evict) begin
                sMask <= 8'h00;
            end
        end
    end

    assign bus.o_pause       = pause;
    assign bus.o_memWriteReq = memWriteReq;
    assign bus.o_memAdr      = memAdr;
    assign bus.o_memData     = memData;
    assign bus.o_memMask     = memMask;
    assign bus.o_idle        = sEmpty & ~memWriteReq;
endmodule

// File: tb/tb_gpu_pixel_line_writer.sv
// Bench for gpu_pixel_line_writer: directed scenarios plus random traffic,
// checked each cycle against a line-level scoreboard model.
module tb_gpu_pixel_line_writer;
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    gpu_pixel_line_writer_if bus();

    gpu_pixel_line_writer dut (
        .clk    (clk),
        .i_nrst (nrst),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [15:0]  adr;
        logic [7:0]   mask;
        logic [127:0] data;
    } line_t;

    // Reference model: the current partial line, plus the lines handed out
    // and not yet acked
    line_t       expQ[$];
    logic [15:0] mAdr;
    logic [7:0]  mMask;
    logic [15:0] mPix[8];

    int checks = 0;
    int failures = 0;
    int ackMode = 0;   // 0 never, 1 always, 2 random

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] maskx(input logic [7:0] m);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = {16{m[k]}};
        return r;
    endfunction

    function automatic line_t curLine();
        line_t l;
        l.adr  = mAdr;
        l.mask = mMask;
        for (int k = 0; k < 8; k++) l.data[16*k +: 16] = mPix[k];
        return l;
    endfunction

    // One clock: checks outputs at the negedge, then advances the model across the posedge.
    task automatic step(output bit took);
        bit pend, expPause, opq, mis, ack;
        logic [15:0] tag;
        case (ackMode)
            0: ack = 1'b0;
            1: ack = 1'b1;
            default: ack = 1'($urandom_range(0, 1));
        endcase
        bus.i_memWriteAck = ack;
        @(negedge clk);
        pend = (expQ.size() > 0);
        tag  = {bus.i_scrY, bus.i_scrX[9:3]};
        opq  = bus.i_validPixel && !bus.i_transparent;
        mis  = (mMask != 0) && (tag != mAdr);
        expPause = pend && ((opq && mis) || (bus.i_flush && !bus.i_validPixel && mMask != 0));
        chk("pause", bus.o_pause, expPause);
        chk("idle", bus.o_idle, (mMask == 0) && !pend);
        chk("req", bus.o_memWriteReq, pend);
        if (pend && bus.o_memWriteReq) begin
            chk("adr", bus.o_memAdr, expQ[0].adr);
            chk("mask", bus.o_memMask, expQ[0].mask);
            chk("data", bus.o_memData & maskx(expQ[0].mask), expQ[0].data & maskx(expQ[0].mask));
        end
        took = !expPause;
        if (!nrst) begin
            expQ.delete();
            mMask = '0;
            mAdr  = '0;
            took  = 1'b1;
        end else begin
            if (pend && ack) void'(expQ.pop_front());
            if (opq && !expPause) begin
                if (mis) begin
                    expQ.push_back(curLine());
                    mMask = '0;
                end
                mPix[bus.i_scrX[2:0]]  = {bus.i_pixel[15] | bus.i_forceMask, bus.i_pixel[14:0]};
                mMask[bus.i_scrX[2:0]] = 1'b1;
                mAdr = tag;
            end else if (bus.i_flush && !bus.i_validPixel && mMask != 0 && !pend) begin
                expQ.push_back(curLine());
                mMask = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic setPix(input int x, input int y, input logic [15:0] c, input bit tr, input bit fm);
        bus.i_validPixel  = 1'b1;
        bus.i_scrX        = 10'(x);
        bus.i_scrY        = 9'(y);
        bus.i_pixel       = c;
        bus.i_transparent = tr;
        bus.i_forceMask   = fm;
        bus.i_flush       = 1'b0;
    endtask

    // Present a pixel and hold it until the model says it was consumed.
    task automatic pix(input int x, input int y, input logic [15:0] c, input bit tr, input bit fm);
        bit took;
        int n = 0;
        setPix(x, y, c, tr, fm);
        do begin
            step(took);
            n++;
        end while (!took && n < 300);
        if (!took) chk("pix_timeout", 0, 1);
        bus.i_validPixel = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        bit took;
        bus.i_validPixel = 1'b0;
        bus.i_flush      = 1'b0;
        for (int i = 0; i < n; i++) step(took);
    endtask

    task automatic flushAll();
        bit took;
        int n = 0;
        ackMode = 1;
        bus.i_validPixel = 1'b0;
        bus.i_flush      = 1'b1;
        while ((mMask != 0 || expQ.size() > 0) && n < 300) begin
            step(took);
            n++;
        end
        if (n >= 300) chk("flush_timeout", 0, 1);
        bus.i_flush = 1'b0;
        step(took);
    endtask

    bit took;

    initial begin
        nrst = 1'b0;
        mAdr = '0;
        mMask = '0;
        for (int k = 0; k < 8; k++) mPix[k] = '0;
        setPix(3, 3, 16'h1234, 1'b0, 1'b0);
        bus.i_memWriteAck = 1'b0;
        // Reset with valid pixels on the bus
        step(took);
        step(took);
        chk("rst_mask", bus.o_memMask, 8'h00);
        chk("rst_adr", bus.o_memAdr, 16'h0000);
        chk("rst_req", bus.o_memWriteReq, 1'b0);
        nrst = 1'b1;
        bus.i_validPixel = 1'b0;
        idleCycles(2);

        // Line fill, then a line change with ack held low
        ackMode = 0;
        for (int k = 0; k < 8; k++) pix(16 + k, 5, 16'h1000 + 16'(k), 1'b0, 1'b0);
        pix(24, 5, 16'h2222, 1'b0, 1'b0);
        chk("fill_adr", bus.o_memAdr, {9'd5, 7'd2});
        chk("fill_mask", bus.o_memMask, 8'hFF);
        for (int k = 0; k < 8; k++)
            chk("fill_slot", bus.o_memData[16*k +: 16], 16'h1000 + 16'(k));

        // Back-pressure: new line while O pending, then a third line
        setPix(0, 6, 16'h0666, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(took);
            chk("bp_hold", took, 1'b0);
        end
        ackMode = 1;
        pix(0, 6, 16'h0666, 1'b0, 1'b0);
        pix(8, 7, 16'h0777, 1'b0, 1'b0);
        flushAll();

        // Transparency and force-mask
        ackMode = 0;
        pix(0, 10, 16'h0123, 1'b0, 1'b1);
        pix(1, 10, 16'h7FFF, 1'b1, 1'b1);
        pix(0, 10, 16'h0456, 1'b0, 1'b1);
        bus.i_flush = 1'b1;
        step(took);
        bus.i_flush = 1'b0;
        chk("tr_mask", bus.o_memMask, 8'h01);
        chk("tr_slot0", bus.o_memData[15:0], 16'h8456);
        flushAll();

        // Partial-line flush
        ackMode = 0;
        for (int k = 0; k < 3; k++) pix(40 + k, 20, 16'h0300 + 16'(k), 1'b0, 1'b0);
        bus.i_flush = 1'b1;
        step(took);
        chk("fl_mask", bus.o_memMask, 8'h07);
        flushAll();
        chk("fl_idle", bus.o_idle, 1'b1);

        // Flush while O pending must pause until ack
        ackMode = 0;
        for (int k = 0; k < 3; k++) pix(k, 30, 16'h0400 + 16'(k), 1'b0, 1'b0);
        pix(64, 30, 16'h0500, 1'b0, 1'b0);
        bus.i_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(took);
            chk("fl_pause", bus.o_pause, 1'b1);
        end
        flushAll();

        // Reset in the middle of a request
        ackMode = 0;
        pix(0, 40, 16'h0AAA, 1'b0, 1'b0);
        pix(8, 40, 16'h0BBB, 1'b0, 1'b0);
        chk("mr_req_before", bus.o_memWriteReq, 1'b1);
        nrst = 1'b0;
        step(took);
        nrst = 1'b1;
        chk("mr_req", bus.o_memWriteReq, 1'b0);
        chk("mr_idle", bus.o_idle, 1'b1);
        idleCycles(5);

        // Random traffic
        ackMode = 2;
        took = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (took) begin
                bus.i_validPixel  = ($urandom_range(0, 3) != 0);
                bus.i_scrX        = 10'($urandom_range(0, 31));
                bus.i_scrY        = 9'($urandom_range(0, 2));
                bus.i_pixel       = 16'($urandom);
                bus.i_transparent = ($urandom_range(0, 4) == 0);
                bus.i_forceMask   = ($urandom_range(0, 7) == 0);
                bus.i_flush       = ($urandom_range(0, 9) == 0);
            end
            nrst = ($urandom_range(0, 499) != 0);
            step(took);
        end
        nrst = 1'b1;
        flushAll();
        chk("end_idle", bus.o_idle, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
